// File: rtl/bus_rr_mux.sv
// N-channel round-robin bus mux with a registered valid/ready output stage.
// Define BUS_MUX_LOCK_EN to add a per-channel lock input for atomic bursts.
module bus_rr_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       req,
`ifdef BUS_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]       lock,
`endif
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    output logic [NUM_CH-1:0]       grant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] hi_win;
    logic [SEL_W-1:0] lo_win;
    logic [SEL_W-1:0] rr_win;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] ptr_nxt;
    logic             hi_found;
    logic             load;
    logic             hold;
    logic [WIDTH-1:0] sel_data;

    assign load = (|req) && (!out_valid || out_ready);

    // Lowest requester at or above ptr, else lowest requester overall.
    always_comb begin
        hi_win   = '0;
        lo_win   = '0;
        hi_found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_win = SEL_W'(k);
                if (SEL_W'(k) >= ptr) begin
                    hi_win   = SEL_W'(k);
                    hi_found = 1'b1;
                end
            end
        end
        rr_win = hi_found ? hi_win : lo_win;
    end

`ifdef BUS_MUX_LOCK_EN
    logic [SEL_W-1:0] last;
    logic             last_vld;

    assign hold   = last_vld && lock[last] && req[last];
    assign winner = hold ? last : rr_win;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            last     <= '0;
            last_vld <= 1'b0;
        end else if (load) begin
            last     <= winner;
            last_vld <= 1'b1;
        end
    end
`else
    assign hold   = 1'b0;
    assign winner = rr_win;
`endif

    assign ptr_nxt = (winner == SEL_W'(NUM_CH - 1)) ? '0 : winner + SEL_W'(1);

    always_comb begin
        sel_data = '0;
        grant    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (winner == SEL_W'(k)) begin
                sel_data = data_in[k*WIDTH +: WIDTH];
                grant[k] = load && !clear;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= winner;
            if (!hold) begin
                ptr <= ptr_nxt;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_rr_mux.sv
// Randomized and directed bench for bus_rr_mux against a behavioural model.
// Define BUS_MUX_LOCK_EN to also exercise the lock feature.
module tb_bus_rr_mux;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int SW = 3;

    logic            clock = 1'b0;
    logic            clear;
    logic [N-1:0]    req;
    logic [N*W-1:0]  data_in;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
`ifdef BUS_MUX_LOCK_EN
    logic [N-1:0]    lock;
`endif

    int checks   = 0;
    int failures = 0;

    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;
    int           m_last;
    bit           m_lvld;
    logic [N-1:0] g_seen;

    bus_rr_mux #(.WIDTH(W), .NUM_CH(N)) dut (
        .clock     (clock),
        .clear     (clear),
        .req       (req),
`ifdef BUS_MUX_LOCK_EN
        .lock      (lock),
`endif
        .data_in   (data_in),
        .grant     (grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
        m_last  = 0;
        m_lvld  = 0;
    endtask

    // Called just after a rising edge; covers one clock cycle.
    task automatic step();
        int           w;
        bit           ld;
        bit           lk;
        logic [N-1:0] eg;
        logic [W-1:0] wd;
        #1;
        lk = 0;
        w  = rr_pick();
`ifdef BUS_MUX_LOCK_EN
        if (m_lvld && lock[m_last] && req[m_last]) begin
            w  = m_last;
            lk = 1;
        end
`endif
        ld = (req != '0) && (!m_valid || out_ready);
        eg = '0;
        wd = '0;
        if (ld) begin
            eg[w] = 1'b1;
            wd    = data_in[w*W +: W];
        end
        g_seen = grant;
        check("grant", grant, eg);
        @(posedge clock);
        #1;
        if (ld) begin
            m_valid = 1'b1;
            m_data  = wd;
            m_ch    = w;
            if (!lk) m_ptr = (w + 1) % N;
            m_last  = w;
            m_lvld  = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        check("out_valid", out_valid, m_valid);
        check("out_ch", out_ch, m_ch);
        check("out_data", out_data, m_data);
    endtask

    // Asserts clear mid-cycle and checks outputs before any edge.
    task automatic do_reset();
        #3;
        clear = 1'b1;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 0);
        check("rst_ch", out_ch, 0);
        check("rst_grant", grant, 0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        model_reset();
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) data_in[k*W +: W] = $urandom;
    endtask

    initial begin
        clear     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b1;
        data_in   = '0;
`ifdef BUS_MUX_LOCK_EN
        lock      = '0;
`endif
        model_reset();
        #1;
        do_reset();

        rand_data();
        repeat (3) step();
        req = 8'hFF;
        do_reset();

        req = 8'h04;
        rand_data();
        data_in[2*W +: W] = 32'hDEADBEEF;
        step();
        check("ss_grant", g_seen, 8'h04);
        check("ss_data", out_data, 32'hDEADBEEF);
        check("ss_ch", out_ch, 2);
        req = '0;
        step();

        do_reset();
        req = 8'hFF;
        for (int k = 0; k < N; k++) data_in[k*W +: W] = k;
        for (int i = 0; i < 9; i++) begin
            step();
            check("fair_ch", out_ch, i % N);
            check("fair_vld", out_valid, 1'b1);
        end

        do_reset();
        req = 8'h08;
        data_in[3*W +: W] = 32'h33;
        step();
        req       = 8'h30;
        out_ready = 1'b0;
        repeat (4) begin
            step();
            check("bp_data", out_data, 32'h33);
            check("bp_grant", g_seen, 0);
        end
        out_ready = 1'b1;
        step();
        check("bp_g4", g_seen, 8'h10);
        req = 8'h20;
        step();
        check("bp_g5", g_seen, 8'h20);

        do_reset();
        req = 8'h40;
        step();
        req = 8'h81;
        step();
        check("wrap_g7", g_seen, 8'h80);
        req = 8'h01;
        step();
        check("wrap_g0", g_seen, 8'h01);

`ifdef BUS_MUX_LOCK_EN
        do_reset();
        req  = 8'h03;
        lock = 8'h01;
        repeat (3) begin
            step();
            check("lock_ch", out_ch, 0);
        end
        lock = 8'h00;
        step();
        check("unlock_ch", out_ch, 1);
`endif

        do_reset();
        repeat (1500) begin
            req       = N'($urandom & $urandom);
            out_ready = ($urandom % 4) != 0;
            rand_data();
`ifdef BUS_MUX_LOCK_EN
            lock = (($urandom % 3) == 0) ? N'($urandom) : '0;
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_rr_mux.md
Name: bus_rr_mux

Overview:
- Parametrised N-channel, WIDTH-bit bus multiplexer for the datapath bus. It succeeds the fixed 2/8/16/32-to-1 mux tree.
- Adds round-robin arbitration across requesting sources and a registered output stage with a valid/ready handshake.
- Sits between multiple bus drivers (register file ports, ALU result, memory data) and a single consumer.
- Guarantees one source per transfer and fair access.

Parameters:
- WIDTH, 32: data width per channel and of out_data.
- NUM_CH, 8: number of input channels, range 2..32.
- SEL_W, $clog2(NUM_CH): width of the channel index.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- req  in  NUM_CH  per-channel request; the source holds req and its data until granted.
- data_in  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- grant  out  NUM_CH  one-hot, combinational; high in the cycle channel k's data is captured.
- out_valid  out  1  the output register holds an untaken word.
- out_ready  in  1  the consumer accepts the word when out_valid && out_ready.
- out_data  out  WIDTH  registered data of the granted channel.
- out_ch  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (clear high, asynchronous):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - grant=0 while clear is asserted.
- Capture condition: load = (|req) && (!out_valid || out_ready).
- Arbitration (combinational):
  - The winner is the first channel with req=1, searching ptr, ptr+1, ..., wrapping modulo NUM_CH.
  - grant = onehot(winner) when load is 1, else grant=0.
  - At most one grant bit is ever high.
- On a rising edge with load=1:
  - out_data <= data_in[winner].
  - out_ch <= winner.
  - out_valid <= 1.
  - ptr <= (winner+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
- On a rising edge with load=0 and out_valid && out_ready: out_valid <= 0. out_data and out_ch hold their last values.
- On a rising edge with load=0 and no acceptance: all state holds; out_data is stable while out_valid=1 and out_ready=0.
- Simultaneous accept and new request: the old word is consumed and the new word is captured in the same edge. out_valid stays 1, giving full throughput of one word per cycle.
- Latency: one cycle from grant to out_valid.
- Back-pressure: while out_valid=1 and out_ready=0, grant=0 and ptr holds. Requests wait, and no data is dropped.
- No requests: grant=0 and ptr holds.
- A req that deasserts before its grant is simply skipped; there is no stored request state.
- clear mid-transfer: the pending word is discarded (out_valid=0) and ptr returns to 0.
- Source contract: a source drops req in the cycle after it sees grant unless it has another word.

Optional Feature:
- Macro: BUS_MUX_LOCK_EN.
- Defined:
  - Adds input port lock [NUM_CH] and an internal register last (SEL_W bits, reset 0) plus a flag last_vld (reset 0).
  - On each capture, last <= winner and last_vld <= 1.
  - If last_vld, lock[last]=1 and req[last]=1 when load=1, channel last wins regardless of ptr, and ptr does not advance. This allows atomic multi-word bursts.
  - When lock[last] drops, normal round-robin resumes from ptr.
- Undefined: there is no lock port and arbitration is pure round-robin.

Test Plan:
- Reset:
  - Stimulus: NUM_CH=8, WIDTH=32, assert clear mid-cycle with req=8'hFF.
  - Response: out_valid=0, out_data=0, out_ch=0 and grant=0 immediately, without waiting for a clock edge.
- Single source:
  - Stimulus: req=8'h04, data_in[2]=32'hDEADBEEF, out_ready=1.
  - Response: grant=8'h04 that cycle; the next cycle out_valid=1, out_data=32'hDEADBEEF, out_ch=2.
- Fairness:
  - Stimulus: req=8'hFF held, out_ready=1, data_in[k]=k.
  - Response: out_ch sequence 0,1,...,7,0 on consecutive cycles, with out_valid continuously 1.
- Back-pressure:
  - Stimulus: capture from ch3 (32'h33), then out_ready=0 for 4 cycles with req=8'h30.
  - Response: out_data stays 32'h33 and grant=0 throughout; after out_ready=1, ch4 is granted, then ch5.
- Wrap and skip:
  - Stimulus: ptr=7 (after a ch6 grant), req=8'h81.
  - Response: ch7 is granted, then ch0.
- Lock (BUS_MUX_LOCK_EN defined):
  - Stimulus: req=8'h03, lock[0]=1 for 3 grants.
  - Response: out_ch=0,0,0.
  - Then lock[0]=0: the next grant is ch1.
